// File: rtl/musa_mem_pkg.sv
// musa_mem_pkg
//   Shared constants and types for the data-memory subsystem.
//   - MEM_ADDR_W / MEM_DATA_W / MEM_DEPTH : geometry of the 2048 x 32 data RAM.
//   - PORT_CORE / PORT_DBG               : requester indices into 2-bit req/gnt vectors.
//   - port_e                             : encoded identity of a single requester.
//   - gnt_to_port()                      : converts a one-hot grant into a port_e.
package musa_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 11;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_DEPTH  = 2048;

    localparam int unsigned PORT_CORE  = 0;
    localparam int unsigned PORT_DBG   = 1;

    typedef enum logic {
        PortCore = 1'b0,
        PortDbg  = 1'b1
    } port_e;

    // Only meaningful for a non-zero one-hot grant; callers gate on |gnt.
    function automatic port_e gnt_to_port(input logic [1:0] gnt);
        if (gnt[1]) begin
            return PortDbg;
        end
        return PortCore;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-requester arbiter with a selectable policy.
//   - Round-robin (prio_fixed=0): a lone requester always wins; under contention
//     the requester that was not granted last wins.
//   - Fixed (prio_fixed=1): requester 0 always wins; requester 1 only when
//     requester 0 is idle. The last-grant record is still kept up to date.
//   Ports:
//     clk        in   clock, all state on posedge
//     rst        in   synchronous active-high reset; forces gnt to 0 this cycle
//     req[1:0]   in   request vector (bit 0 = core, bit 1 = debug/loader)
//     prio_fixed in   policy select
//     gnt[1:0]   out  one-hot grant, combinational
module rr_arb2
    import musa_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       prio_fixed,
    output logic [1:0] gnt
);

    port_e last_gnt_q;
    port_e last_gnt_d;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: core wins under fixed priority, or when the
                // debug port was the previous winner.
                2'b11:   gnt = (prio_fixed || (last_gnt_q == PortDbg)) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (|gnt) begin
            last_gnt_d = gnt_to_port(gnt);
        end
    end

    // Resetting to the debug port makes the core win the first contended cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= PortDbg;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter
//   Shares the single-ported data RAM between the core MEM stage (port 0) and
//   the loader/debug port (port 1). At most one access is granted per cycle;
//   read data returns one cycle after the grant with a per-port valid strobe.
//   Ports:
//     clk, rst                  clock and synchronous active-high reset
//     pN_req/we/addr/wdata      requester N access; held stable until granted
//     pN_gnt                    combinational grant for requester N
//     pN_rvalid                 rdata holds requester N's read data this cycle
//     rdata                     shared read data (straight from the RAM)
//     p0_stall                  core request pending but not granted
//     mem_addr/mem_data_in      RAM address and write data
//     mem_read/mem_write        RAM enables, never both high
//     mem_data_out              RAM registered read data
module mem_data_arbiter
    import musa_mem_pkg::*;
#(
    parameter int unsigned ADDR_W        = MEM_ADDR_W,
    parameter int unsigned DATA_W        = MEM_DATA_W,
    parameter int unsigned CORE_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic              p0_stall,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_data_out
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       we_sel;
    logic [1:0] rd_pend_q;
    logic [1:0] rd_pend_d;

    assign req = {p1_req, p0_req};

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .prio_fixed (CORE_PRIORITY != 0),
        .gnt        (gnt)
    );

    // Grants, RAM mux and enables.
    always_comb begin
        p0_gnt  = gnt[PORT_CORE];
        p1_gnt  = gnt[PORT_DBG];
        any_gnt = |gnt;

        // With no grant the core's fields pass through; both enables are low
        // so the RAM ignores them.
        if (gnt[PORT_DBG]) begin
            mem_addr    = p1_addr;
            mem_data_in = p1_wdata;
            we_sel      = p1_we;
        end else begin
            mem_addr    = p0_addr;
            mem_data_in = p0_wdata;
            we_sel      = p0_we;
        end

        mem_read  = any_gnt & ~we_sel;
        mem_write = any_gnt &  we_sel;

        // gnt is already zero in reset; the extra term keeps stall low too.
        p0_stall  = p0_req & ~p0_gnt & ~rst;
    end

    // One-hot record of which port's read is in flight inside the RAM.
    always_comb begin
        rd_pend_d = {p1_gnt & ~p1_we, p0_gnt & ~p0_we};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 2'b00;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    // Gating with rst drops the strobe of a read issued just before reset
    // rises, in the very cycle its data would have come back.
    always_comb begin
        p0_rvalid = rd_pend_q[PORT_CORE] & ~rst;
        p1_rvalid = rd_pend_q[PORT_DBG]  & ~rst;
    end

    assign rdata = mem_data_out;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Bench for mem_data_arbiter: instance 0 uses round-robin, instance 1 fixed
// core priority. Each instance has its own behavioural RAM. Expected grants,
// enables and read returns come from a rule-level model (last winner, shadow
// memory, one pending read) advanced once per cycle.
module tb_mem_data_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst          [2];
    logic          p0_req       [2];
    logic          p0_we        [2];
    logic [AW-1:0] p0_addr      [2];
    logic [DW-1:0] p0_wdata     [2];
    logic          p1_req       [2];
    logic          p1_we        [2];
    logic [AW-1:0] p1_addr      [2];
    logic [DW-1:0] p1_wdata     [2];
    logic          p0_gnt       [2];
    logic          p1_gnt       [2];
    logic          p0_rvalid    [2];
    logic          p1_rvalid    [2];
    logic          p0_stall     [2];
    logic [DW-1:0] rdata        [2];
    logic [AW-1:0] mem_addr     [2];
    logic [DW-1:0] mem_data_in  [2];
    logic          mem_read     [2];
    logic          mem_write    [2];
    logic [DW-1:0] mem_data_out [2];

    for (genvar i = 0; i < 2; i++) begin : g_inst
        logic [DW-1:0] ram [2048];
        logic [DW-1:0] ram_q;

        always @(posedge clk) begin
            if (mem_write[i]) ram[mem_addr[i]] <= mem_data_in[i];
            if (mem_read[i])  ram_q <= ram[mem_addr[i]];
        end
        assign mem_data_out[i] = ram_q;

        mem_data_arbiter #(.CORE_PRIORITY(i)) u_dut (
            .clk          (clk),
            .rst          (rst[i]),
            .p0_req       (p0_req[i]),
            .p0_we        (p0_we[i]),
            .p0_addr      (p0_addr[i]),
            .p0_wdata     (p0_wdata[i]),
            .p0_gnt       (p0_gnt[i]),
            .p0_rvalid    (p0_rvalid[i]),
            .p0_stall     (p0_stall[i]),
            .p1_req       (p1_req[i]),
            .p1_we        (p1_we[i]),
            .p1_addr      (p1_addr[i]),
            .p1_wdata     (p1_wdata[i]),
            .p1_gnt       (p1_gnt[i]),
            .p1_rvalid    (p1_rvalid[i]),
            .rdata        (rdata[i]),
            .mem_addr     (mem_addr[i]),
            .mem_data_in  (mem_data_in[i]),
            .mem_read     (mem_read[i]),
            .mem_write    (mem_write[i]),
            .mem_data_out (mem_data_out[i])
        );
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, per instance.
    int            mdl_last  [2];
    int            pend_port [2];
    logic [DW-1:0] pend_data [2];
    logic [DW-1:0] shadow    [2][2048];
    int            exp_g;

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (inst %0d): observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic r0, input logic w0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] v0,
                         input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] v1);
        p0_req[d] = r0; p0_we[d] = w0; p0_addr[d] = a0; p0_wdata[d] = v0;
        p1_req[d] = r1; p1_we[d] = w1; p1_addr[d] = a1; p1_wdata[d] = v1;
    endtask

    // Check one cycle of instance d at the falling edge, then advance the model
    // and return just after the next rising edge.
    task automatic tick(input int d);
        int            g;
        logic          wsel;
        logic [AW-1:0] asel;
        logic [DW-1:0] dsel;
        @(negedge clk);
        g = -1;
        if (!rst[d]) begin
            if (p0_req[d] && p1_req[d]) g = (d == 1) ? 0 : ((mdl_last[d] == 0) ? 1 : 0);
            else if (p0_req[d])         g = 0;
            else if (p1_req[d])         g = 1;
        end
        wsel = (g == 1) ? p1_we[d]    : p0_we[d];
        asel = (g == 1) ? p1_addr[d]  : p0_addr[d];
        dsel = (g == 1) ? p1_wdata[d] : p0_wdata[d];

        chk("p0_gnt",    d, 32'(p0_gnt[d]),    32'(g == 0));
        chk("p1_gnt",    d, 32'(p1_gnt[d]),    32'(g == 1));
        chk("p0_stall",  d, 32'(p0_stall[d]),  32'(p0_req[d] && !rst[d] && g != 0));
        chk("mem_read",  d, 32'(mem_read[d]),  32'(g >= 0 && !wsel));
        chk("mem_write", d, 32'(mem_write[d]), 32'(g >= 0 && wsel));
        if (g >= 0) chk("mem_addr", d, 32'(mem_addr[d]), 32'(asel));
        if (g >= 0 && wsel) chk("mem_data_in", d, mem_data_in[d], dsel);
        chk("p0_rvalid", d, 32'(p0_rvalid[d]), 32'(!rst[d] && pend_port[d] == 0));
        chk("p1_rvalid", d, 32'(p1_rvalid[d]), 32'(!rst[d] && pend_port[d] == 1));
        if (!rst[d] && pend_port[d] >= 0) chk("rdata", d, rdata[d], pend_data[d]);

        exp_g = g;
        pend_port[d] = -1;
        if (rst[d]) begin
            mdl_last[d] = 1;
        end else if (g >= 0) begin
            mdl_last[d] = g;
            if (wsel) begin
                shadow[d][asel] = dsel;
            end else begin
                pend_port[d] = g;
                pend_data[d] = shadow[d][asel];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic prewrite(input int d);
        for (int k = 0; k < 16; k++) begin
            drive(d, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(k), $urandom);
            tick(d);
        end
        drive(d, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic random_run(input int d, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            rst[d] = ($urandom_range(0, 59) == 0);
            if (!p0_req[d] && $urandom_range(0, 2) != 0) begin
                p0_req[d] = 1'b1; p0_we[d] = 1'($urandom_range(0, 1));
                p0_addr[d] = AW'($urandom_range(0, 15)); p0_wdata[d] = $urandom;
            end
            if (!p1_req[d] && $urandom_range(0, 2) != 0) begin
                p1_req[d] = 1'b1; p1_we[d] = 1'($urandom_range(0, 1));
                p1_addr[d] = AW'($urandom_range(0, 15)); p1_wdata[d] = $urandom;
            end
            tick(d);
            if (exp_g == 0) p0_req[d] = 1'b0;
            if (exp_g == 1) p1_req[d] = 1'b0;
        end
        rst[d] = 1'b0;
        drive(d, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            mdl_last[d] = 1;
            pend_port[d] = -1;
            pend_data[d] = '0;
            drive(d, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        end

        // Reset held 3 cycles with both ports requesting, then release.
        drive(0, 1'b1, 1'b1, 11'h7FE, 32'h0000_0001, 1'b1, 1'b1, 11'h7FD, 32'h0000_0002);
        repeat (3) tick(0);
        rst[0] = 1'b0;
        tick(0);                                   // core wins first contended cycle
        drive(0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 11'h7FD, 32'h0000_0002);
        tick(0);
        prewrite(0);

        // Single write then read at the top address.
        drive(0, 1'b1, 1'b1, 11'h7FF, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        tick(0);
        drive(0, 1'b1, 1'b0, 11'h7FF, '0, 1'b0, 1'b0, '0, '0);
        tick(0);
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick(0);

        // Round-robin contention on continuous reads.
        drive(0, 1'b1, 1'b1, 11'h010, 32'h1111_0010, 1'b0, 1'b0, '0, '0);
        tick(0);
        drive(0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 11'h020, 32'h2222_0020);
        tick(0);
        drive(0, 1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b0, 11'h020, '0);
        repeat (6) tick(0);
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick(0);

        // Read-after-write across ports.
        drive(0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 11'h100, 32'hA5A5_A5A5);
        tick(0);
        drive(0, 1'b1, 1'b0, 11'h100, '0, 1'b0, 1'b0, '0, '0);
        tick(0);
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick(0);

        // Reset right after a read grant; then a contended cycle.
        drive(0, 1'b1, 1'b0, 11'h100, '0, 1'b0, 1'b0, '0, '0);
        tick(0);
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        rst[0] = 1'b1;
        tick(0);
        rst[0] = 1'b0;
        tick(0);
        drive(0, 1'b1, 1'b0, 11'h010, '0, 1'b1, 1'b0, 11'h020, '0);
        tick(0);
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick(0);

        random_run(0, 400);

        // Fixed-priority instance.
        tick(1);
        rst[1] = 1'b0;
        prewrite(1);
        drive(1, 1'b1, 1'b0, 11'h003, '0, 1'b1, 1'b1, 11'h005, 32'h1234_5678);
        repeat (5) tick(1);
        p0_req[1] = 1'b0;
        tick(1);                                   // debug write finally granted
        drive(1, 1'b1, 1'b0, 11'h005, '0, 1'b0, 1'b0, '0, '0);
        tick(1);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        tick(1);

        random_run(1, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Two-port arbiter that shares the single-ported 2048 x 32 data RAM between the core's MEM stage (port 0) and the loader/debug port (port 1). It sits between those requesters and the data memory. Each cycle it grants at most one access, drives the RAM's address, write-data, read-enable and write-enable lines, and returns read data one cycle later with a per-port valid strobe. Port 0 gets a stall output for the pipeline hazard logic.

## Interface
- ADDR_W, 11: word address width; RAM depth is 2**ADDR_W.
- DATA_W, 32: data word width.
- CORE_PRIORITY, 0: 0 = round-robin between ports; 1 = fixed priority to port 0.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- p0_req / p1_req  in  1  access request; held until granted.
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high.
- p0_addr / p1_addr  in  ADDR_W  word address; stable while req is high.
- p0_wdata / p1_wdata  in  DATA_W  write data; stable while req is high.
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational).
- p0_rvalid / p1_rvalid  out  1  read data valid on rdata (registered).
- rdata  out  DATA_W  read data, shared by both ports; equals mem_data_out.
- p0_stall  out  1  p0_req & ~p0_gnt.
- mem_addr  out  ADDR_W  RAM address.
- mem_data_in  out  DATA_W  RAM write data.
- mem_read  out  1  RAM read enable.
- mem_write  out  1  RAM write enable.
- mem_data_out  in  DATA_W  RAM registered read data.

## Operation
- State:
  - last_gnt: 1 bit, the last port granted.
  - rd_pend: 2 bits, one-hot, the port whose read was issued in the previous cycle.
- Arbitration, when CORE_PRIORITY=0:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port != last_gnt is granted.
  - last_gnt updates only on a grant.
- Arbitration, when CORE_PRIORITY=1:
  - p0_req always wins. p1 is granted only when p0_req=0.
  - last_gnt is still tracked but has no effect.
- Mux to the RAM:
  - mem_addr and mem_data_in come from the granted port.
  - With no grant, mem_addr and mem_data_in hold the port 0 values. They are don't-care because both enables are 0.
- Enables:
  - mem_read = any_gnt & ~we_sel.
  - mem_write = any_gnt & we_sel.
  - They are never both high.
- Read return:
  - rd_pend <= {p1_gnt & ~p1_we, p0_gnt & ~p0_we}.
  - pN_rvalid = rd_pend[N].
  - rdata is valid only while the matching rvalid is high.
- Writes produce no response. A gnt means the write is committed at the end of that cycle.
- Reset (rst=1):
  - All gnt, mem_read, mem_write and p0_stall are forced to 0 in the same cycle.
  - On the next edge: rd_pend <= 0 and last_gnt <= 1, so port 0 wins the first contended cycle.
  - A read granted in the cycle before rst rises has its rvalid suppressed.
- Reset values of registered outputs: p0_rvalid=0, p1_rvalid=0.

## Timing
- Grant: combinational, same cycle as req. Zero-wait when uncontended.
- Read latency: 1 cycle. Read granted in cycle N gives rvalid high in cycle N+1, with rdata = RAM[addr].
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Write then read, same address:
  - Write granted in cycle N, read granted in N+1: rvalid in N+2 returns the new data.
  - Same-cycle write and read is impossible (single grant).
- Contention with round-robin: strict alternation. Worst-case wait is 1 cycle per port.
- rdata is not held after rvalid drops. Requesters capture it in the rvalid cycle.

## Structure
- Shared package `musa_mem_pkg`: MEM_ADDR_W=11, MEM_DATA_W=32, MEM_DEPTH=2048, and port index constants PORT_CORE=0 and PORT_DBG=1.
- One sub-module, `rr_arb2`:
  - Inputs: clk, rst, req[1:0], prio_fixed.
  - Output: one-hot gnt[1:0].
  - Holds last_gnt.
- Top level holds the mux, enables and rd_pend.

## Test plan
- Reset values: hold rst 3 cycles with both req=1 → gnt=0, mem_read=0, mem_write=0, rvalid=0 throughout. First cycle after release → p0_gnt=1.
- Single read: p0 writes 0xDEADBEEF to addr 0x7FF, then p0 reads 0x7FF → p0_gnt same cycle, p0_rvalid exactly 1 cycle later, rdata=0xDEADBEEF, p1_rvalid=0.
- Round-robin contention, CORE_PRIORITY=0: both ports read addrs 0x010 and 0x020 continuously for 6 cycles → grants go p0, p1, p0, p1, p0, p1. Each rvalid arrives 1 cycle after its grant with the correct data. p0_stall is high on the p1 cycles.
- Fixed priority, CORE_PRIORITY=1: p0_req held for 5 cycles, p1 requesting write of 0x12345678 to 0x005 → p1_gnt=0 for 5 cycles, p1 granted in cycle 6. A following read of 0x005 returns 0x12345678.
- Read-after-write: p1 writes 0xA5A5A5A5 to 0x100 in cycle N, p0 reads 0x100 in N+1 → p0_rvalid in N+2 with rdata=0xA5A5A5A5.
- Reset mid-read: read granted in cycle N, rst=1 in N+1 → p0_rvalid=0 in N+1 and N+2. The next contended grant after release goes to port 0.
